// File: rtl/garegga_snd_rom_arb.sv
// rtl/garegga_snd_rom_arb.sv - shares one SDRAM read port between the sound Z80 ROM and the OKI PCM fetch,
// with a one-entry data cache per requester.
module garegga_snd_rom_arb #(
  parameter int             MAW         = 22,
  parameter logic [MAW-1:0] Z80_BASE    = '0,
  parameter logic [MAW-1:0] PCM_BASE    = '0,
  parameter logic [7:0]     PCM_MAXWAIT = 8'd32
) (
  input  logic           CLK96,
  input  logic           RESET96_N,
  input  logic           ROMZ80_CS,
  input  logic [16:0]    ROMZ80_ADDR,
  output logic           ROMZ80_OK,
  output logic [7:0]     ROMZ80_DOUT,
  input  logic           PCM_CS,
  input  logic [19:0]    PCM_ADDR,
  output logic           PCM_OK,
  output logic [7:0]     PCM_DOUT,
  input  logic           PCM_FLUSH,
  output logic           MEM_CS,
  output logic [MAW-1:0] MEM_ADDR,
  input  logic           MEM_OK,
  input  logic [7:0]     MEM_DOUT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t      state, state_nxt;
  logic        sel;              // 0: Z80, 1: PCM
  logic [19:0] lat_addr;
  logic        z_valid, p_valid;
  logic [16:0] z_tag;
  logic [19:0] p_tag;
  logic [7:0]  z_data, p_data;
  logic [7:0]  pcm_wait;

  logic z_hit, p_hit, z_pend, p_pend, pcm_first, grant, mem_done, busy;

  // A flush in progress already hides the PCM entry so the new bank never sees stale data.
  assign z_hit     = ROMZ80_CS & z_valid & (ROMZ80_ADDR == z_tag);
  assign p_hit     = PCM_CS & p_valid & ~PCM_FLUSH & (PCM_ADDR == p_tag);
  assign z_pend    = ROMZ80_CS & ~z_hit;
  assign p_pend    = PCM_CS & ~p_hit;
  assign pcm_first = p_pend & (~z_pend | (pcm_wait >= PCM_MAXWAIT));
  assign grant     = (state == IDLE) & (z_pend | p_pend);
  assign mem_done  = (state == WAIT) & MEM_OK;
  assign busy      = (state != IDLE);

  assign ROMZ80_OK   = z_hit;
  assign ROMZ80_DOUT = z_data;
  assign PCM_OK      = p_hit;
  assign PCM_DOUT    = p_data;

  always_ff @(posedge CLK96) begin
    if (!RESET96_N) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (z_pend | p_pend) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (MEM_OK) state_nxt = GAP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      sel      <= 1'b0;
      lat_addr <= '0;
      MEM_CS   <= 1'b0;
      MEM_ADDR <= '0;
      z_valid  <= 1'b0;
      z_tag    <= '0;
      z_data   <= '0;
      p_valid  <= 1'b0;
      p_tag    <= '0;
      p_data   <= '0;
      pcm_wait <= '0;
    end else begin
      if (grant) begin
        sel      <= pcm_first;
        lat_addr <= pcm_first ? PCM_ADDR : {3'b000, ROMZ80_ADDR};
      end
      if (state == ISSUE) begin
        MEM_CS   <= 1'b1;
        MEM_ADDR <= (sel ? PCM_BASE : Z80_BASE) + {{(MAW-20){1'b0}}, lat_addr};
      end
      if (mem_done) begin
        MEM_CS <= 1'b0;
        if (sel) begin
          p_valid <= 1'b1;
          p_tag   <= lat_addr;
          p_data  <= MEM_DOUT;
        end else begin
          z_valid <= 1'b1;
          z_tag   <= lat_addr[16:0];
          z_data  <= MEM_DOUT;
        end
      end
      if (PCM_FLUSH) p_valid <= 1'b0;
      // Waiting time counts only while PCM is not the one being served.
      if (!PCM_CS || (grant && pcm_first))
        pcm_wait <= '0;
      else if (p_pend && !(busy && sel) && (pcm_wait != 8'hFF))
        pcm_wait <= pcm_wait + 8'd1;
    end
  end

endmodule

// File: tb/tb_garegga_snd_rom_arb.sv
// tb/tb_garegga_snd_rom_arb.sv - randomized and directed checks of the sound ROM arbiter against a cache/SDRAM model.
module tb_garegga_snd_rom_arb;
  localparam logic [21:0] ZB = 22'h3F0000;
  localparam logic [21:0] PB = 22'h100000;

  logic        clk = 1'b0;
  logic        rst_n, z_cs, p_cs, flush, mem_ok;
  logic [16:0] z_addr;
  logic [19:0] p_addr;
  logic [7:0]  mem_dout;
  logic        z_ok, p_ok, mem_cs;
  logic [7:0]  z_dout, p_dout;
  logic [21:0] mem_addr;

  always #5 clk = ~clk;

  garegga_snd_rom_arb #(.MAW(22), .Z80_BASE(ZB), .PCM_BASE(PB), .PCM_MAXWAIT(8'd8)) dut (
    .CLK96(clk), .RESET96_N(rst_n),
    .ROMZ80_CS(z_cs), .ROMZ80_ADDR(z_addr), .ROMZ80_OK(z_ok), .ROMZ80_DOUT(z_dout),
    .PCM_CS(p_cs), .PCM_ADDR(p_addr), .PCM_OK(p_ok), .PCM_DOUT(p_dout), .PCM_FLUSH(flush),
    .MEM_CS(mem_cs), .MEM_ADDR(mem_addr), .MEM_OK(mem_ok), .MEM_DOUT(mem_dout)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference cache contents and SDRAM responder state
  bit          mz_v, mp_v;
  logic [16:0] mz_t;
  logic [19:0] mp_t;
  logic [7:0]  mz_d, mp_d;
  bit          sd_busy, flush_on_ok, force_ok, ok_fill;
  int          sd_cnt, lat, cyc;
  logic [21:0] sd_addr;
  bit          obs_mem_cs, obs_zok, obs_pok;
  logic [21:0] obs_mem_addr;

  function automatic logic [7:0] memf(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
  endfunction

  task automatic sdram_drive();
    mem_ok = 1'b0;
    if (force_ok) begin
      mem_ok = 1'b1;
      mem_dout = 8'hEE;
      force_ok = 1'b0;
    end else if (rst_n && mem_cs) begin
      if (!sd_busy) begin
        sd_busy = 1'b1;
        sd_cnt = 0;
        sd_addr = mem_addr;
      end else chk("mem_addr_hold", 32'(mem_addr), 32'(sd_addr));
      if (sd_cnt == lat) begin
        mem_ok = 1'b1;
        mem_dout = memf(sd_addr);
        sd_busy = 1'b0;
        if (flush_on_ok) begin
          flush = 1'b1;
          flush_on_ok = 1'b0;
        end
      end
      sd_cnt++;
    end
  endtask

  // One clock: drive SDRAM response, compare outputs with the model, then apply the edge to the model.
  task automatic cycle();
    logic [21:0] t;
    sdram_drive();
    #1;
    obs_mem_cs = mem_cs;
    obs_mem_addr = mem_addr;
    obs_zok = z_ok;
    obs_pok = p_ok;
    ok_fill = mem_ok && mem_cs && rst_n;
    chk("z80_ok", 32'(z_ok), 32'(z_cs & mz_v & (z_addr == mz_t)));
    chk("z80_dout", 32'(z_dout), 32'(mz_d));
    chk("pcm_ok", 32'(p_ok), 32'(p_cs & mp_v & ~flush & (p_addr == mp_t)));
    chk("pcm_dout", 32'(p_dout), 32'(mp_d));
    @(posedge clk);
    if (!rst_n) begin
      mz_v = 0; mp_v = 0; mz_t = '0; mp_t = '0; mz_d = '0; mp_d = '0;
      sd_busy = 0;
    end else begin
      if (ok_fill) begin
        if (sd_addr >= PB && sd_addr < PB + 22'h100000) begin
          t = sd_addr - PB;
          mp_v = 1; mp_t = t[19:0]; mp_d = mem_dout;
        end else begin
          t = sd_addr - ZB;
          mz_v = 1; mz_t = t[16:0]; mz_d = mem_dout;
        end
      end
      if (flush) mp_v = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 0; z_cs = 0; p_cs = 0; flush = 0; z_addr = '0; p_addr = '0;
    flush_on_ok = 0; force_ok = 0;
    cycle();
    cycle();
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1;
  endtask

  logic [21:0] txa[$];
  logic [16:0] zpool[4] = '{17'h100, 17'h101, 17'h1FFFF, 17'h0};
  logic [19:0] ppool[4] = '{20'h0, 20'h5, 20'hFFFFF, 20'h80000};

  initial begin
    int c_cs, c_ok, c_zok, gap_low, first_pcm, pfills, fired, nre, first_fill;
    bit prev_cs, ended, changed;
    mem_ok = 0; mem_dout = '0; lat = 5; cyc = 0; sd_busy = 0;
    rst_n = 0; z_cs = 0; p_cs = 0; flush = 0; z_addr = '0; p_addr = '0;
    @(posedge clk);
    #1;

    // Z80 miss timing, then a cached re-read
    reset_dut();
    lat = 5; z_cs = 1; z_addr = 17'h100;
    c_cs = -1; c_ok = -1; c_zok = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (obs_mem_cs && c_cs < 0) begin
        c_cs = i;
        chk("t1_mem_addr", 32'(obs_mem_addr), 32'(ZB + 22'h100));
      end
      if (ok_fill && c_ok < 0) c_ok = i;
      if (obs_zok) begin c_zok = i; break; end
    end
    chk("t1_cs_delay", c_cs, 2);
    chk("t1_ok_after_memok", c_zok, c_ok + 1);
    chk("t1_latency", c_zok, 8);
    z_cs = 0; cycle(); cycle();
    z_cs = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t1_reread_ok", 32'(obs_zok), 32'd1);
      chk("t1_reread_no_mem", 32'(obs_mem_cs), 32'd0);
    end

    // Simultaneous misses: Z80 first, idle gap, then PCM
    reset_dut();
    lat = 2; z_cs = 1; z_addr = 17'h200; p_cs = 1; p_addr = 20'h300;
    txa.delete(); prev_cs = 0; gap_low = 0; ended = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (obs_mem_cs && !prev_cs) txa.push_back(obs_mem_addr);
      if (!obs_mem_cs && prev_cs) ended = 1;
      if (ended && txa.size() == 1 && !obs_mem_cs) gap_low++;
      prev_cs = obs_mem_cs;
      if (obs_pok) break;
    end
    chk("t2_tx_count", txa.size(), 2);
    if (txa.size() >= 2) begin
      chk("t2_first_z80", 32'(txa[0]), 32'(ZB + 22'h200));
      chk("t2_second_pcm", 32'(txa[1]), 32'(PB + 22'h300));
    end
    chk("t2_gap_low", 32'(gap_low >= 1 && gap_low <= 3), 32'd1);

    // Z80 keeps missing; PCM must still get through
    reset_dut();
    lat = 1; z_cs = 1; z_addr = '0; p_cs = 1; p_addr = 20'h40;
    txa.delete(); prev_cs = 0; first_pcm = -1; pfills = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (obs_mem_cs && !prev_cs) begin
        if (first_pcm < 0 && obs_mem_addr >= PB && obs_mem_addr < PB + 22'h100000) first_pcm = txa.size();
        txa.push_back(obs_mem_addr);
      end
      prev_cs = obs_mem_cs;
      if (obs_zok) z_addr = z_addr + 17'd1;
      if (obs_pok) begin pfills++; p_addr = p_addr + 20'd1; end
    end
    chk("t3_pcm_tx_index", first_pcm, 2);
    chk("t3_pcm_not_starved", 32'(pfills >= 20), 32'd1);

    // Flush coinciding with the PCM fill
    reset_dut();
    lat = 3; p_cs = 1; p_addr = 20'h55; flush_on_ok = 1;
    prev_cs = 0; fired = -10; nre = 0;
    for (int i = 0; i < 40; i++) begin
      flush = 0;
      cycle();
      if (obs_mem_cs && !prev_cs) begin
        nre++;
        chk("t4_addr", 32'(obs_mem_addr), 32'(PB + 22'h55));
      end
      prev_cs = obs_mem_cs;
      if (i == fired + 1) chk("t4_pok_after_flush", 32'(obs_pok), 32'd0);
      if (ok_fill && fired < 0) fired = i;
    end
    chk("t4_reissue", nre, 2);
    chk("t4_final_ok", 32'(obs_pok), 32'd1);

    // PCM address changes while its fetch is in flight
    reset_dut();
    lat = 4; p_cs = 1; p_addr = 20'h10;
    txa.delete(); prev_cs = 0; changed = 0; first_fill = -10;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (obs_mem_cs && !prev_cs) txa.push_back(obs_mem_addr);
      prev_cs = obs_mem_cs;
      if (obs_mem_cs && !changed) begin p_addr = 20'h20; changed = 1; end
      if (i == first_fill + 1) chk("t5_pok_stale", 32'(obs_pok), 32'd0);
      if (ok_fill && first_fill < 0) first_fill = i;
      if (obs_pok) break;
    end
    chk("t5_tx_count", txa.size(), 2);
    if (txa.size() >= 2) begin
      chk("t5_first_old", 32'(txa[0]), 32'(PB + 22'h10));
      chk("t5_second_new", 32'(txa[1]), 32'(PB + 22'h20));
    end
    chk("t5_final_ok", 32'(obs_pok), 32'd1);

    // Reset during WAIT, then a late MEM_OK
    reset_dut();
    lat = 6; z_cs = 1; z_addr = 17'h77;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (obs_mem_cs) break;
    end
    cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("t6_mem_cs", 32'(mem_cs), 32'd0);
    chk("t6_z_ok", 32'(z_ok), 32'd0);
    chk("t6_p_ok", 32'(p_ok), 32'd0);
    z_cs = 0; force_ok = 1;
    cycle();
    z_cs = 1;
    cycle();
    chk("t6_no_fill", 32'(obs_zok), 32'd0);

    // Random traffic against the model
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) z_cs = ~z_cs;
      if ($urandom_range(0, 7) == 0) p_cs = ~p_cs;
      if ($urandom_range(0, 5) == 0) z_addr = zpool[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) p_addr = ppool[$urandom_range(0, 3)];
      flush = ($urandom_range(0, 29) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      if (!sd_busy) lat = $urandom_range(0, 4);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
